// File: rtl/brisc_pkg.sv
// Shared b-risc definitions: datapath width, RV32I base opcodes and immediate formats.
package brisc_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // IMM_R selects a zero immediate for register-register instructions.
   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_R
   } imm_type_e;

   // All base opcodes end in 2'b11, so a full 7-bit match also rejects compressed encodings.
   function automatic logic is_rv32i_opcode(input logic [6:0] opc);
      logic legal;
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
         OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: legal = 1'b1;
         default:                                                 legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode channel: fetch (master) offers an instruction, decode (slave) answers with if_ready.
interface decode_stage_if #(
   parameter int XLEN = brisc_pkg::XLEN
) ();

   logic            if_valid;
   logic [XLEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;
   logic            if_ready;

   modport master (
      output if_valid,
      output if_instr,
      output if_pc,
      input  if_ready
   );

   modport slave (
      input  if_valid,
      input  if_instr,
      input  if_pc,
      output if_ready
   );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: rebuilds the I/S/B/U/J immediate from instruction bits [31:7], sign-extended to XLEN.
module imm_gen
   import brisc_pkg::*;
#(
   parameter int XLEN = brisc_pkg::XLEN
) (
   input  logic [31:7]     instr,
   input  imm_type_e       imm_type,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (imm_type)
         IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm32 = {instr[31:12], 12'b0};
         IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// b-risc decode stage: IF/ID and ID/EX pipeline registers, control decode and load-use interlock.
// Optional DECODE_ILLEGAL_TRAP_EN: flag non-RV32I opcodes in ex_illegal and suppress their control.
module decode_stage
   import brisc_pkg::*;
#(
   parameter int XLEN      = brisc_pkg::XLEN,
   parameter int REG_IDX_W = 5
) (
   input  logic                 clk,
   input  logic                 aresetn,
   decode_stage_if.slave        fetch,
   input  logic                 flush,
   input  logic                 ex_stall,
   output logic [REG_IDX_W-1:0] rd_reg_a,
   output logic [REG_IDX_W-1:0] rd_reg_b,
   input  logic [XLEN-1:0]      rf_data_a,
   input  logic [XLEN-1:0]      rf_data_b,
   output logic                 ex_valid,
   output logic [XLEN-1:0]      ex_pc,
   output logic [XLEN-1:0]      ex_imm,
   output logic [XLEN-1:0]      ex_rs1_data,
   output logic [XLEN-1:0]      ex_rs2_data,
   output logic [REG_IDX_W-1:0] ex_rs1,
   output logic [REG_IDX_W-1:0] ex_rs2,
   output logic [REG_IDX_W-1:0] ex_rd,
   output logic [6:0]           ex_opcode,
   output logic [2:0]           ex_funct3,
   output logic                 ex_funct7_b5,
   output logic                 ex_mem_read,
   output logic                 ex_mem_write,
   output logic                 ex_reg_write,
   output logic                 ex_illegal
);

   // IF/ID register
   logic            id_valid_reg;
   logic [XLEN-1:0] id_instr_reg;
   logic [XLEN-1:0] id_pc_reg;

   // ID/EX register
   logic                 ex_valid_reg;
   logic [XLEN-1:0]      ex_pc_reg;
   logic [XLEN-1:0]      ex_imm_reg;
   logic [XLEN-1:0]      ex_rs1_data_reg;
   logic [XLEN-1:0]      ex_rs2_data_reg;
   logic [REG_IDX_W-1:0] ex_rs1_reg;
   logic [REG_IDX_W-1:0] ex_rs2_reg;
   logic [REG_IDX_W-1:0] ex_rd_reg;
   logic [6:0]           ex_opcode_reg;
   logic [2:0]           ex_funct3_reg;
   logic                 ex_funct7_b5_reg;
   logic                 ex_mem_read_reg;
   logic                 ex_mem_write_reg;
   logic                 ex_reg_write_reg;
   logic                 ex_illegal_reg;

   // Instruction fields of the IF/ID entry
   logic [6:0]           opcode;
   logic [REG_IDX_W-1:0] rs1_idx;
   logic [REG_IDX_W-1:0] rs2_idx;
   logic [REG_IDX_W-1:0] rd_idx;

   assign opcode  = id_instr_reg[6:0];
   assign rs1_idx = REG_IDX_W'(id_instr_reg[19:15]);
   assign rs2_idx = REG_IDX_W'(id_instr_reg[24:20]);
   assign rd_idx  = REG_IDX_W'(id_instr_reg[11:7]);

   logic      uses_rs1;
   logic      uses_rs2;
   logic      dec_mem_read;
   logic      dec_mem_write;
   logic      dec_reg_write;
   logic      dec_illegal;
   imm_type_e imm_type;

   always_comb begin
      uses_rs1      = 1'b1;
      uses_rs2      = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      dec_reg_write = 1'b0;
      imm_type      = IMM_I;
      case (opcode)
         OPC_LUI, OPC_AUIPC: begin
            uses_rs1      = 1'b0;
            dec_reg_write = 1'b1;
            imm_type      = IMM_U;
         end
         OPC_JAL: begin
            uses_rs1      = 1'b0;
            dec_reg_write = 1'b1;
            imm_type      = IMM_J;
         end
         OPC_JALR:   dec_reg_write = 1'b1;
         OPC_BRANCH: begin
            uses_rs2 = 1'b1;
            imm_type = IMM_B;
         end
         OPC_LOAD: begin
            dec_mem_read  = 1'b1;
            dec_reg_write = 1'b1;
         end
         OPC_STORE: begin
            uses_rs2      = 1'b1;
            dec_mem_write = 1'b1;
            imm_type      = IMM_S;
         end
         OPC_OP_IMM: dec_reg_write = 1'b1;
         OPC_OP: begin
            uses_rs2      = 1'b1;
            dec_reg_write = 1'b1;
            imm_type      = IMM_R;
         end
         default: ;
      endcase
   end

`ifdef DECODE_ILLEGAL_TRAP_EN
   assign dec_illegal = !is_rv32i_opcode(opcode);
`else
   assign dec_illegal = 1'b0;
`endif

   logic ctl_mem_read;
   logic ctl_mem_write;
   logic ctl_reg_write;

   assign ctl_mem_read  = dec_mem_read  & ~dec_illegal;
   assign ctl_mem_write = dec_mem_write & ~dec_illegal;
   assign ctl_reg_write = dec_reg_write & ~dec_illegal & (rd_idx != '0);

   logic [XLEN-1:0] dec_imm;

   imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .instr    (id_instr_reg[31:7]),
      .imm_type (imm_type),
      .imm      (dec_imm)
   );

   // A load in EX cannot feed the instruction behind it until it has left EX.
   logic hazard;
   assign hazard = ex_valid_reg & ex_mem_read_reg & (ex_rd_reg != '0) & id_valid_reg &
                   ((uses_rs1 & (ex_rd_reg == rs1_idx)) | (uses_rs2 & (ex_rd_reg == rs2_idx)));

   assign fetch.if_ready = !ex_stall && !hazard;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         id_valid_reg     <= 1'b0;
         id_instr_reg     <= '0;
         id_pc_reg        <= '0;
         ex_valid_reg     <= 1'b0;
         ex_pc_reg        <= '0;
         ex_imm_reg       <= '0;
         ex_rs1_data_reg  <= '0;
         ex_rs2_data_reg  <= '0;
         ex_rs1_reg       <= '0;
         ex_rs2_reg       <= '0;
         ex_rd_reg        <= '0;
         ex_opcode_reg    <= '0;
         ex_funct3_reg    <= '0;
         ex_funct7_b5_reg <= 1'b0;
         ex_mem_read_reg  <= 1'b0;
         ex_mem_write_reg <= 1'b0;
         ex_reg_write_reg <= 1'b0;
         ex_illegal_reg   <= 1'b0;
      end else if (flush) begin
         id_valid_reg     <= 1'b0;
         ex_valid_reg     <= 1'b0;
         ex_mem_read_reg  <= 1'b0;
         ex_mem_write_reg <= 1'b0;
         ex_reg_write_reg <= 1'b0;
         ex_illegal_reg   <= 1'b0;
      end else if (!ex_stall) begin
         // Bubbles keep the previous payload so EX sees deterministic don't-care fields.
         if (hazard || !id_valid_reg) begin
            ex_valid_reg     <= 1'b0;
            ex_mem_read_reg  <= 1'b0;
            ex_mem_write_reg <= 1'b0;
            ex_reg_write_reg <= 1'b0;
            ex_illegal_reg   <= 1'b0;
         end else begin
            ex_valid_reg     <= 1'b1;
            ex_pc_reg        <= id_pc_reg;
            ex_imm_reg       <= dec_imm;
            ex_rs1_data_reg  <= rf_data_a;
            ex_rs2_data_reg  <= rf_data_b;
            ex_rs1_reg       <= rs1_idx;
            ex_rs2_reg       <= rs2_idx;
            ex_rd_reg        <= rd_idx;
            ex_opcode_reg    <= opcode;
            ex_funct3_reg    <= id_instr_reg[14:12];
            ex_funct7_b5_reg <= id_instr_reg[30];
            ex_mem_read_reg  <= ctl_mem_read;
            ex_mem_write_reg <= ctl_mem_write;
            ex_reg_write_reg <= ctl_reg_write;
            ex_illegal_reg   <= dec_illegal;
         end
         if (!hazard) begin
            id_valid_reg <= fetch.if_valid;
            if (fetch.if_valid) begin
               id_instr_reg <= fetch.if_instr;
               id_pc_reg    <= fetch.if_pc;
            end
         end
      end
   end

   assign rd_reg_a     = rs1_idx;
   assign rd_reg_b     = rs2_idx;
   assign ex_valid     = ex_valid_reg;
   assign ex_pc        = ex_pc_reg;
   assign ex_imm       = ex_imm_reg;
   assign ex_rs1_data  = ex_rs1_data_reg;
   assign ex_rs2_data  = ex_rs2_data_reg;
   assign ex_rs1       = ex_rs1_reg;
   assign ex_rs2       = ex_rs2_reg;
   assign ex_rd        = ex_rd_reg;
   assign ex_opcode    = ex_opcode_reg;
   assign ex_funct3    = ex_funct3_reg;
   assign ex_funct7_b5 = ex_funct7_b5_reg;
   assign ex_mem_read  = ex_mem_read_reg;
   assign ex_mem_write = ex_mem_write_reg;
   assign ex_reg_write = ex_reg_write_reg;
   assign ex_illegal   = ex_illegal_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic against a behavioural pipeline model.
module tb_decode_stage;

   localparam logic [6:0] M_LUI    = 7'h37;
   localparam logic [6:0] M_AUIPC  = 7'h17;
   localparam logic [6:0] M_JAL    = 7'h6F;
   localparam logic [6:0] M_JALR   = 7'h67;
   localparam logic [6:0] M_BRANCH = 7'h63;
   localparam logic [6:0] M_LOAD   = 7'h03;
   localparam logic [6:0] M_STORE  = 7'h23;
   localparam logic [6:0] M_OPIMM  = 7'h13;
   localparam logic [6:0] M_OP     = 7'h33;
   localparam logic [6:0] M_MISC   = 7'h0F;
   localparam logic [6:0] M_SYSTEM = 7'h73;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        f7;
      logic        mr;
      logic        mw;
      logic        rw;
      logic        ill;
   } ex_t;

   logic        clk = 1'b0;
   logic        aresetn;
   logic        flush;
   logic        ex_stall;
   logic [4:0]  rd_reg_a, rd_reg_b;
   logic [31:0] rf_data_a = '0, rf_data_b = '0;
   logic        ex_valid;
   logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic        ex_funct7_b5, ex_mem_read, ex_mem_write, ex_reg_write, ex_illegal;

   decode_stage_if #(.XLEN(32)) fif ();

   decode_stage dut (
      .clk          (clk),
      .aresetn      (aresetn),
      .fetch        (fif.slave),
      .flush        (flush),
      .ex_stall     (ex_stall),
      .rd_reg_a     (rd_reg_a),
      .rd_reg_b     (rd_reg_b),
      .rf_data_a    (rf_data_a),
      .rf_data_b    (rf_data_b),
      .ex_valid     (ex_valid),
      .ex_pc        (ex_pc),
      .ex_imm       (ex_imm),
      .ex_rs1_data  (ex_rs1_data),
      .ex_rs2_data  (ex_rs2_data),
      .ex_rs1       (ex_rs1),
      .ex_rs2       (ex_rs2),
      .ex_rd        (ex_rd),
      .ex_opcode    (ex_opcode),
      .ex_funct3    (ex_funct3),
      .ex_funct7_b5 (ex_funct7_b5),
      .ex_mem_read  (ex_mem_read),
      .ex_mem_write (ex_mem_write),
      .ex_reg_write (ex_reg_write),
      .ex_illegal   (ex_illegal)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Register file contents (constant during the run); served on the falling edge.
   logic [31:0] rf [32];
   always @(negedge clk) begin
      rf_data_a = rf[rd_reg_a];
      rf_data_b = rf[rd_reg_b];
   end

   // Behavioural model state
   logic        m_id_valid;
   logic [31:0] m_id_instr, m_id_pc;
   ex_t         m_ex;

   function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
      logic signed [31:0] t;
      t = v << (32 - bits);
      return t >>> (32 - bits);
   endfunction

   function automatic logic m_uses_rs1(input logic [31:0] i);
      return !(i[6:0] inside {M_LUI, M_AUIPC, M_JAL});
   endfunction

   function automatic logic m_uses_rs2(input logic [31:0] i);
      return i[6:0] inside {M_BRANCH, M_STORE, M_OP};
   endfunction

   function automatic logic m_hazard();
      logic [4:0] r1, r2;
      r1 = m_id_instr[19:15];
      r2 = m_id_instr[24:20];
      return m_ex.valid && m_ex.mr && m_ex.rd != 0 && m_id_valid &&
             ((m_uses_rs1(m_id_instr) && m_ex.rd == r1) || (m_uses_rs2(m_id_instr) && m_ex.rd == r2));
   endfunction

   function automatic logic m_ready();
      return !ex_stall && !m_hazard();
   endfunction

   function automatic ex_t m_decode(input logic [31:0] i, input logic [31:0] pc);
      ex_t e;
      logic [6:0] op;
      op = i[6:0];
      e = '0;
      e.valid = 1'b1;
      e.pc  = pc;
      e.rs1 = i[19:15];
      e.rs2 = i[24:20];
      e.rd  = i[11:7];
      e.opc = op;
      e.f3  = i[14:12];
      e.f7  = i[30];
      e.d1  = rf[i[19:15]];
      e.d2  = rf[i[24:20]];
      case (op)
         M_LUI, M_AUIPC: e.imm = i & 32'hFFFF_F000;
         M_JAL:          e.imm = sext({i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
         M_BRANCH:       e.imm = sext({i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
         M_STORE:        e.imm = sext({i[31:25], i[11:7]}, 12);
         M_OP:           e.imm = 32'd0;
         default:        e.imm = sext(i >> 20, 12);
      endcase
      e.mr = (op == M_LOAD);
      e.mw = (op == M_STORE);
      e.rw = (op inside {M_LUI, M_AUIPC, M_JAL, M_JALR, M_LOAD, M_OPIMM, M_OP}) && (e.rd != 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
      e.ill = !(op inside {M_LUI, M_AUIPC, M_JAL, M_JALR, M_BRANCH, M_LOAD, M_STORE,
                           M_OPIMM, M_OP, M_MISC, M_SYSTEM});
      if (e.ill) begin
         e.mr = 1'b0;
         e.mw = 1'b0;
         e.rw = 1'b0;
      end
`endif
      return e;
   endfunction

   task automatic m_reset();
      m_id_valid = 1'b0;
      m_id_instr = '0;
      m_id_pc    = '0;
      m_ex       = '0;
   endtask

   task automatic m_bubble();
      m_ex.valid = 1'b0;
      m_ex.mr    = 1'b0;
      m_ex.mw    = 1'b0;
      m_ex.rw    = 1'b0;
      m_ex.ill   = 1'b0;
   endtask

   // One clock edge of the pipeline, following the flush > stall > hazard > advance priority.
   task automatic m_edge();
      logic hz;
      hz = m_hazard();
      if (flush) begin
         m_id_valid = 1'b0;
         m_bubble();
      end else if (ex_stall) begin
      end else if (hz) begin
         m_bubble();
      end else begin
         if (m_id_valid) m_ex = m_decode(m_id_instr, m_id_pc);
         else            m_bubble();
         m_id_valid = fif.if_valid;
         if (fif.if_valid) begin
            m_id_instr = fif.if_instr;
            m_id_pc    = fif.if_pc;
         end
      end
   endtask

   function automatic ex_t dut_ex();
      ex_t e;
      e.valid = ex_valid;     e.pc  = ex_pc;        e.imm = ex_imm;
      e.d1    = ex_rs1_data;  e.d2  = ex_rs2_data;
      e.rs1   = ex_rs1;       e.rs2 = ex_rs2;       e.rd  = ex_rd;
      e.opc   = ex_opcode;    e.f3  = ex_funct3;    e.f7  = ex_funct7_b5;
      e.mr    = ex_mem_read;  e.mw  = ex_mem_write; e.rw  = ex_reg_write;
      e.ill   = ex_illegal;
      return e;
   endfunction

   // ex_illegal of a bubble is not defined, so it is ignored when the entry is not valid.
   function automatic ex_t masked(input ex_t e);
      ex_t r;
      r = e;
      if (!r.valid) r.ill = 1'b0;
      return r;
   endfunction

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic fl, input logic st);
      fif.if_valid = v;
      fif.if_instr = instr;
      fif.if_pc    = pc;
      flush        = fl;
      ex_stall     = st;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      m_edge();
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
         tick();
      end
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (dut_ex() !== ex_t'(0)) begin
         errors++;
         $display("FAIL reset_ex got %h want 0", dut_ex());
      end
      checks++;
      if (fif.if_ready !== 1'b1 || rd_reg_a !== 5'd0 || rd_reg_b !== 5'd0) begin
         errors++;
         $display("FAIL reset_misc got ready=%0b a=%0d b=%0d want ready=1 a=0 b=0",
                  fif.if_ready, rd_reg_a, rd_reg_b);
      end
      aresetn = 1'b1;
      $display("reset: ex_valid=%0b if_ready=%0b", ex_valid, fif.if_ready);
   endtask

   task automatic test_addi();
      drive(1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
      tick();
      checks++;
      if (rd_reg_a !== 5'd0) begin
         errors++;
         $display("FAIL addi_rd_reg_a got %0d want 0", rd_reg_a);
      end
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd1 || ex_imm !== 32'd5 || ex_reg_write !== 1'b1) begin
         errors++;
         $display("FAIL addi_ex got v=%0b rd=%0d imm=%h rw=%0b want v=1 rd=1 imm=5 rw=1",
                  ex_valid, ex_rd, ex_imm, ex_reg_write);
      end
      checks++;
      if (masked(dut_ex()) !== masked(m_ex)) begin
         errors++;
         $display("FAIL addi_model got %h want %h", dut_ex(), m_ex);
      end
      $display("addi: ex_pc=%h ex_rd=%0d ex_imm=%h", ex_pc, ex_rd, ex_imm);
   endtask

   task automatic test_load_use();
      idle(2);
      drive(1'b1, 32'h0000_A103, 32'h4, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h0011_01B3, 32'h8, 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      checks++;
      if (fif.if_ready !== 1'b0 || m_ready() !== 1'b0) begin
         errors++;
         $display("FAIL lu_ready got %0b want 0", fif.if_ready);
      end
      tick();
      checks++;
      if (ex_valid !== 1'b0 || masked(dut_ex()) !== masked(m_ex)) begin
         errors++;
         $display("FAIL lu_bubble got %h want %h", dut_ex(), m_ex);
      end
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      checks++;
      if (fif.if_ready !== 1'b1) begin
         errors++;
         $display("FAIL lu_ready_clear got %0b want 1", fif.if_ready);
      end
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_rs1 !== 5'd2 || ex_rs2 !== 5'd1 || ex_pc !== 32'h8 ||
          masked(dut_ex()) !== masked(m_ex)) begin
         errors++;
         $display("FAIL lu_add got %h want %h", dut_ex(), m_ex);
      end
      $display("load_use: add in EX pc=%h rs1=%0d rs2=%0d", ex_pc, ex_rs1, ex_rs2);
   endtask

   task automatic test_branch_x0();
      idle(2);
      drive(1'b1, 32'hFE00_0EE3, 32'h20, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h0000_A003, 32'h24, 1'b0, 1'b0);
      tick();
      checks++;
      if (ex_imm !== 32'hFFFF_FFFC || ex_reg_write !== 1'b0 || ex_valid !== 1'b1) begin
         errors++;
         $display("FAIL beq_imm got imm=%h rw=%0b want imm=fffffffc rw=0", ex_imm, ex_reg_write);
      end
      drive(1'b1, 32'h0000_01B3, 32'h28, 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      checks++;
      if (fif.if_ready !== 1'b1) begin
         errors++;
         $display("FAIL x0_no_stall got ready=%0b want 1", fif.if_ready);
      end
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h28 || masked(dut_ex()) !== masked(m_ex)) begin
         errors++;
         $display("FAIL x0_use got %h want %h", dut_ex(), m_ex);
      end
      $display("branch_x0: beq imm ok path, use of x0 pc=%h", ex_pc);
   endtask

   task automatic test_flush();
      idle(2);
      drive(1'b1, 32'h0000_A103, 32'h40, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h0011_01B3, 32'h44, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h0010_0213, 32'h48, 1'b1, 1'b0);
      checks++;
      if (fif.if_ready !== m_ready()) begin
         errors++;
         $display("FAIL flush_ready got %0b want %0b", fif.if_ready, m_ready());
      end
      tick();
      checks++;
      if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0) begin
         errors++;
         $display("FAIL flush_ex got v=%0b mr=%0b rw=%0b want 0 0 0", ex_valid, ex_mem_read, ex_reg_write);
      end
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      checks++;
      if (fif.if_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_ready_after got %0b want 1", fif.if_ready);
      end
      tick();
      checks++;
      if (ex_valid !== 1'b0 || masked(dut_ex()) !== masked(m_ex)) begin
         errors++;
         $display("FAIL flush_residue got %h want %h", dut_ex(), m_ex);
      end
      $display("flush: ex_valid=%0b after flush and drain", ex_valid);
   endtask

   task automatic test_stall();
      idle(2);
      drive(1'b1, 32'h0070_0093, 32'h100, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'h0090_0113, 32'h104, 1'b0, 1'b1);
         checks++;
         if (fif.if_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready cyc %0d got %0b want 0", k, fif.if_ready);
         end
         tick();
         checks++;
         if (masked(dut_ex()) !== masked(m_ex) || rd_reg_a !== 5'd0 || rd_reg_b !== 5'd7) begin
            errors++;
            $display("FAIL stall_hold cyc %0d got %h a=%0d b=%0d want %h a=0 b=7",
                     k, dut_ex(), rd_reg_a, rd_reg_b, m_ex);
         end
      end
      drive(1'b1, 32'h0090_0113, 32'h104, 1'b0, 1'b0);
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || ex_imm !== 32'd7) begin
         errors++;
         $display("FAIL stall_release1 got v=%0b pc=%h imm=%h want 1 100 7", ex_valid, ex_pc, ex_imm);
      end
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h104 || ex_rd !== 5'd2) begin
         errors++;
         $display("FAIL stall_release2 got v=%0b pc=%h rd=%0d want 1 104 2", ex_valid, ex_pc, ex_rd);
      end
      tick();
      checks++;
      if (ex_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_no_dup got v=%0b pc=%h want v=0", ex_valid, ex_pc);
      end
      // Asynchronous reset in the middle of a stalled cycle
      drive(1'b1, 32'h0000_A103, 32'h108, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h0011_01B3, 32'h10C, 1'b0, 1'b1);
      tick();
      #2;
      aresetn  = 1'b0;
      ex_stall = 1'b0;
      #1;
      m_reset();
      checks++;
      if (dut_ex() !== ex_t'(0) || fif.if_ready !== 1'b1 || rd_reg_a !== 5'd0) begin
         errors++;
         $display("FAIL reset_mid_stall got %h ready=%0b a=%0d want 0 ready=1 a=0",
                  dut_ex(), fif.if_ready, rd_reg_a);
      end
      @(negedge clk);
      aresetn = 1'b1;
      $display("stall: release order 100,104; reset mid-stall ex_valid=%0b", ex_valid);
   endtask

   task automatic test_illegal();
      logic exp_ill;
`ifdef DECODE_ILLEGAL_TRAP_EN
      exp_ill = 1'b1;
`else
      exp_ill = 1'b0;
`endif
      idle(2);
      drive(1'b1, 32'h0000_007F, 32'h200, 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_illegal !== exp_ill || ex_reg_write !== 1'b0 ||
          ex_mem_read !== 1'b0 || ex_mem_write !== 1'b0) begin
         errors++;
         $display("FAIL illegal got v=%0b ill=%0b rw=%0b mr=%0b mw=%0b want v=1 ill=%0b 0 0 0",
                  ex_valid, ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write, exp_ill);
      end
      $display("illegal: ex_illegal=%0b", ex_illegal);
   endtask

   function automatic logic [31:0] gen_instr();
      logic [6:0]  ops [9];
      logic [31:0] r;
      ops = '{M_LUI, M_AUIPC, M_JAL, M_JALR, M_BRANCH, M_LOAD, M_STORE, M_OPIMM, M_OP};
      r = $urandom;
      r[6:0]   = ($urandom_range(0, 2) == 0) ? M_LOAD : ops[$urandom_range(0, 8)];
      r[11:7]  = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      return r;
   endfunction

   task automatic test_random();
      logic        cv, fl, st, take_new, exp_ready;
      logic [31:0] ci, cp;
      int          start_err;
      start_err = errors;
      cv = 1'b0;
      ci = '0;
      cp = 32'h1000;
      take_new = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (take_new) begin
            cv = ($urandom_range(0, 3) != 0);
            ci = gen_instr();
            cp = cp + 32'd4;
         end
         fl = ($urandom_range(0, 15) == 0);
         st = ($urandom_range(0, 7) == 0);
         drive(cv, ci, cp, fl, st);
         exp_ready = m_ready();
         checks++;
         if (fif.if_ready !== exp_ready) begin
            errors++;
            $display("FAIL rand_ready cyc %0d got %0b want %0b", i, fif.if_ready, exp_ready);
         end
         take_new = !cv || fl || exp_ready;
         tick();
         checks++;
         if (masked(dut_ex()) !== masked(m_ex)) begin
            errors++;
            $display("FAIL rand_ex cyc %0d got %h want %h", i, dut_ex(), m_ex);
         end
         if (m_id_valid) begin
            checks++;
            if (rd_reg_a !== m_id_instr[19:15] || rd_reg_b !== m_id_instr[24:20]) begin
               errors++;
               $display("FAIL rand_rdreg cyc %0d got %0d/%0d want %0d/%0d", i, rd_reg_a, rd_reg_b,
                        m_id_instr[19:15], m_id_instr[24:20]);
            end
         end
      end
      $display("random: 400 cycles, %0d new errors", errors - start_err);
   endtask

   initial begin
      rf[0] = 32'd0;
      for (int k = 1; k < 32; k++) rf[k] = $urandom;
      test_reset();
      test_addi();
      test_load_use();
      test_branch_x0();
      test_flush();
      test_stall();
      test_illegal();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the b-risc pipeline. Holds the IF/ID pipeline register and drives register-file read indices from it. Captures register-file read data, decoded control and the sign-extended immediate into the ID/EX register. Detects load-use hazards against the instruction in EX, inserting a bubble and stalling fetch.

## Interface
- `XLEN`, 32: datapath and instruction width.
- `REG_IDX_W`, 5: register index width.
- `clk` in 1: clock. State updates on rising edge; the register file samples `rd_reg_a`/`rd_reg_b` on the falling edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `if_valid` in 1: fetch presents an instruction.
- `if_instr` in XLEN: instruction word.
- `if_pc` in XLEN: instruction address.
- `if_ready` out 1: decode accepts the fetch instruction this cycle.
- `flush` in 1: EX branch/jump redirect; kill IF/ID and ID/EX.
- `ex_stall` in 1: downstream hold; freeze both registers.
- `rd_reg_a`, `rd_reg_b` out REG_IDX_W: rs1/rs2 of the IF/ID instruction, to the register file.
- `rf_data_a`, `rf_data_b` in XLEN: register-file read data.
- `ex_valid` out 1: ID/EX holds a live instruction.
- `ex_pc`, `ex_imm`, `ex_rs1_data`, `ex_rs2_data` out XLEN: ID/EX payload.
- `ex_rs1`, `ex_rs2`, `ex_rd` out REG_IDX_W: indices for forwarding and writeback.
- `ex_opcode` out 7, `ex_funct3` out 3, `ex_funct7_b5` out 1: ALU/branch selection.
- `ex_mem_read`, `ex_mem_write`, `ex_reg_write` out 1: control.
- `ex_illegal` out 1: illegal-opcode flag (see Configuration).

## Operation
- IF/ID register: `id_valid`, `id_instr`, `id_pc`.
- `rd_reg_a = id_instr[19:15]`, `rd_reg_b = id_instr[24:20]`, driven from registered state.
- Source usage:
  - `uses_rs1` = not LUI/AUIPC/JAL.
  - `uses_rs2` = BRANCH/STORE/OP.
- Immediate types I/S/B/U/J. Sign-extend from `instr[31]`; B and J have bit 0 = 0. R-type imm = 0.
- `reg_write` set for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP. Forced to 0 when rd == 0.
- `hazard = ex_valid & ex_mem_read & ex_rd != 0 & id_valid & ((uses_rs1 & ex_rd == rs1) | (uses_rs2 & ex_rd == rs2))`.
- `if_ready = !ex_stall & !hazard`. `flush` does not deassert it; fetch is already redirected.
- Per-edge priority:
  1. Reset.
  2. `flush`: `id_valid ← 0`, `ex_valid ← 0`, all ex control ← 0.
  3. `ex_stall`: hold both registers.
  4. `hazard`: hold IF/ID; ID/EX ← bubble (`ex_valid`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write` = 0).
  5. Normal: ID/EX ← decoded IF/ID; IF/ID ← fetch input, with `id_valid ← if_valid`.
- An invalid IF/ID entry decodes to a bubble.
- Payload fields of a bubble are don't-care, but must be deterministic: hold previous values.

## Timing
- Reset: every output and internal register is 0, so `ex_valid = 0` and `if_ready = 1`.
- Latency: instruction accepted at edge N appears in ID/EX at edge N+1.
- Register-file data is read at the falling edge between N and N+1 and captured at N+1. A writeback landing at edge N is therefore visible, with no internal bypass.
- Load-use costs exactly one bubble cycle. On the following edge the load has left EX and the hazard clears.
- `flush` together with `hazard` or `ex_stall`: flush wins. The instruction is dropped.
- Reset mid-stall: everything returns to 0 immediately (asynchronous).

## Configuration
- `DECODE_ILLEGAL_TRAP_EN`:
  - Defined: any opcode outside the RV32I set (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM), or `instr[1:0] != 2'b11`, sets `ex_illegal`. Control outputs are forced to 0 while `ex_valid` stays 1.
  - Undefined: `ex_illegal` is tied to 0. Unknown opcodes decode as a NOP with all control at 0.

## Structure
- Shared package `brisc_pkg`:
  - opcode localparams (`OPC_LUI` … `OPC_SYSTEM`);
  - immediate-type enum (`IMM_I`, `IMM_S`, `IMM_B`, `IMM_U`, `IMM_J`);
  - `XLEN`.
- Sub-module `imm_gen`: combinational; instruction plus imm type in, XLEN immediate out.
- Pipeline registers, hazard detection and control decode stay in `decode_stage`.

## Test plan
- Reset, then `if_instr=0x00500093` (addi x1,x0,5) at PC 0x0:
  - next edge: `rd_reg_a=0`;
  - edge after: `ex_valid=1`, `ex_rd=1`, `ex_imm=5`, `ex_reg_write=1`.
- Load-use sequence `0x0000A103` (lw x2,0(x1)), then `0x001101B3` (add x3,x2,x1):
  - one bubble: `ex_valid=0`, `if_ready=0` for one cycle;
  - then the add reaches EX with `ex_rs1=2`, `ex_rs2=1`.
- `0xFE000EE3` (beq x0,x0,-4) → `ex_imm=0xFFFFFFFC`, `ex_reg_write=0`. Load to x0 followed by a use of x0 → no stall.
- `flush=1` with a live instruction in IF/ID and a load-use pending → next edge `ex_valid=0`, `id_valid=0`, no bubble-hold residue.
- `ex_stall=1` for 3 cycles → ID/EX and IF/ID outputs unchanged, `if_ready=0`. Release → pipeline resumes with no loss or duplication.
- With `DECODE_ILLEGAL_TRAP_EN` defined, `if_instr=0x0000007F` → `ex_illegal=1`, `ex_reg_write=0`. Without it → `ex_illegal=0`.
